// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - pipelined single-port data memory with byte enables and range check (optional DMEM_CLEAR_ON_RESET_EN sweep)
module data_memory_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 65536,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // Sync-read word; only meaningful while s1_rd is set, so it carries no reset
    logic [DATA_WIDTH-1:0] rd_q;

    // Stage 1 control flags: cleared by reset so in-flight requests vanish
    logic s1_valid;
    logic s1_err;
    logic s1_rd;
    logic [DATA_WIDTH-1:0] s1_rdata;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [IDX_W-1:0] clr_cnt;
`endif

    assign accept   = req_valid && req_ready;
    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign idx      = req_addr[IDX_W-1:0];

    // Control FSM: optional clear sweep after reset, then RUN forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`else
            state     <= ST_RUN;
            req_ready <= 1'b1;
            busy      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_CLEAR: begin
`ifdef DMEM_CLEAR_ON_RESET_EN
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
`else
                    state     <= ST_RUN;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
`endif
                end
                default: begin
                    state     <= ST_RUN;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: sweep writes, byte-lane writes and the registered read port
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end
`endif
        if (accept && in_range) begin
            if (req_write) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (req_be[i]) begin
                        mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end else begin
                rd_q <= mem[idx];
            end
        end
    end

    // First response stage: records what kind of response each accepted request needs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_rd    <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && !in_range;
            s1_rd    <= accept && !req_write && in_range;
        end
    end

    // Writes and errored requests return zero data
    assign s1_rdata = s1_rd ? rd_q : '0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic                  s2_err;
            logic [DATA_WIDTH-1:0] s2_rdata;

            // Second response stage for the two-cycle latency build
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_rdata <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    s2_rdata <= s1_rdata;
                end
            end

            assign rsp_valid = s2_valid;
            assign rsp_err   = s2_err;
            assign rsp_rdata = s2_rdata;
        end else begin : g_lat1
            assign rsp_valid = s1_valid;
            assign rsp_err   = s1_err;
            assign rsp_rdata = s1_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized scoreboard bench for data_memory_ctrl at latency 1 and 2
module tb_data_memory_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be    = '0;

    logic          rdy  [2];
    logic          rv   [2];
    logic          rerr [2];
    logic          bsy  [2];
    logic [DW-1:0] rdat [2];

    data_memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0]), .busy(bsy[0])
    );

    data_memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1]), .busy(bsy[1])
    );

    typedef struct {
        int            due;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          expq [2][$];
    logic [DW-1:0] model [DEPTH];
    int            cyc   = 0;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_out(input int k);
        rsp_t e;
        if (expq[k].size() > 0 && expq[k][0].due == cyc) begin
            e = expq[k].pop_front();
            check($sformatf("rsp_valid_L%0d", k + 1), {31'b0, rv[k]}, 32'd1);
            check($sformatf("rsp_err_L%0d", k + 1), {31'b0, rerr[k]}, {31'b0, e.err});
            check($sformatf("rsp_rdata_L%0d", k + 1), {16'b0, rdat[k]}, {16'b0, e.data});
        end else begin
            check($sformatf("idle_valid_L%0d", k + 1), {31'b0, rv[k]}, 32'd0);
            check($sformatf("idle_err_L%0d", k + 1), {31'b0, rerr[k]}, 32'd0);
            check($sformatf("idle_rdata_L%0d", k + 1), {16'b0, rdat[k]}, 32'd0);
        end
    endtask

    // One clock: the model accepts what the DUT is offered when ready, then both outputs are checked
    task automatic step();
        rsp_t e;
        if (req_valid && rdy[0] && rst_n) begin
            e.err  = (int'(req_addr) >= DEPTH);
            e.data = '0;
            if (!e.err) begin
                if (req_write) begin
                    for (int i = 0; i < 2; i++)
                        if (req_be[i]) model[int'(req_addr)][8*i +: 8] = req_wdata[8*i +: 8];
                end else begin
                    e.data = model[int'(req_addr)];
                end
            end
            for (int k = 0; k < 2; k++) begin
                e.due = cyc + 1 + k;
                expq[k].push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_out(0);
        check_out(1);
    endtask

    task automatic req(input logic w, input int a, input logic [DW-1:0] d, input logic [1:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = AW'(a);
        req_wdata = d;
        req_be    = be;
        step();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic hold_req);
        int waited;
        rst_n = 1'b0;
        #1;
        check("reset_valid_L1", {31'b0, rv[0]}, 32'd0);
        check("reset_valid_L2", {31'b0, rv[1]}, 32'd0);
        check("reset_rdata_L1", {16'b0, rdat[0]}, 32'd0);
        check("reset_err_L2", {31'b0, rerr[1]}, 32'd0);
        expq[0].delete();
        expq[1].delete();
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        if (hold_req) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = AW'(7);
            req_be    = 2'b11;
        end
        waited = 0;
        while (!rdy[0] && waited < 5000) begin
            check("busy_in_clear", {31'b0, bsy[0]}, 32'd1);
            waited++;
            step();
        end
        check("clear_cycles", waited, DEPTH);
        check("busy_after_clear", {31'b0, bsy[1]}, 32'd0);
        if (hold_req) step();
        req_valid = 1'b0;
`else
        waited = 0;
        check("ready_after_reset", {31'b0, rdy[0]}, 32'd1);
        check("busy_after_reset", {31'b0, bsy[0]}, 32'd0);
        check("ready_after_reset_L2", {31'b0, rdy[1]}, 32'd1);
        if (hold_req) req(1'b0, 7, '0, 2'b11);
        req_valid = 1'b0;
        check("wait_cycles", waited, 0);
`endif
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0)
                req(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                    DW'($urandom), 2'($urandom_range(0, 3)));
            else
                idle(1);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2;
        do_reset(1'b1);
        idle(1);
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int a = 0; a < 16; a++) req(1'b0, a, '0, 2'b11);
        idle(2);
`endif
        // Preload every word so the model never holds unknown contents
        for (int a = 0; a < DEPTH; a++) req(1'b1, a, DW'(16'h0101 * a), 2'b11);
        idle(2);

        req(1'b1, 5, 16'hBEEF, 2'b11);
        idle(1);
        req(1'b0, 5, '0, 2'b11);
        idle(2);

        req(1'b1, 16, 16'h1234, 2'b11);
        req(1'b1, 16, 16'hABCD, 2'b10);
        req(1'b0, 16, '0, 2'b00);
        req(1'b1, 17, 16'hFFFF, 2'b00);
        req(1'b0, 17, '0, 2'b11);
        idle(2);

        req(1'b1, 1000, 16'h5555, 2'b11);
        req(1'b0, 1000, '0, 2'b11);
        req(1'b0, 1023, '0, 2'b11);
        req(1'b0, 999, '0, 2'b11);
        idle(2);

        for (int a = 1; a <= 5; a++) req(1'b0, a, '0, 2'b11);
        idle(3);

        random_traffic(1500);
        idle(2);

        req(1'b0, 1, '0, 2'b11);
        req(1'b0, 2, '0, 2'b11);
        do_reset(1'b0);
        idle(5);
        for (int a = 20; a < 24; a++) req(1'b0, a, '0, 2'b11);
        idle(2);

        random_traffic(300);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
